// File: rtl/add_subt_pkg.sv
// Shared constants and helpers for the FPU significand add/subtract path.
package add_subt_pkg;

  localparam logic OP_ADD = 1'b0;
  localparam logic OP_SUB = 1'b1;

  localparam int SWR_DEFAULT = 26;

  // Widest significand the negate helper supports; callers truncate to their own width.
  localparam int NEG_MAX_W = 64;

  function automatic logic [NEG_MAX_W-1:0] twos_negate(input logic [NEG_MAX_W-1:0] v);
    return ~v + NEG_MAX_W'(1);
  endfunction

endpackage

// File: rtl/add_subt_pipe_pg_adder.sv
// Combinational adder producing sum, propagate vector, internal carries and carry-out.
module pg_adder #(
  parameter int SWR = 26
) (
  input  logic [SWR-1:0] a,
  input  logic [SWR-1:0] b,
  input  logic           cin,
  output logic [SWR-1:0] s,
  output logic [SWR-1:0] p,
  output logic [SWR-1:1] cn,
  output logic           co
);

  logic [SWR:0] sum;

  assign sum = {1'b0, a} + {1'b0, b} + {{SWR{1'b0}}, cin};
  assign s   = sum[SWR-1:0];
  assign co  = sum[SWR];
  assign p   = a ^ b;
  // Carry into bit i is recovered from s[i] = p[i] ^ c[i].
  assign cn  = p[SWR-1:1] ^ s[SWR-1:1];

endmodule

// File: rtl/add_subt_pipe.sv
// Two-stage elastic significand adder/subtractor: stage 1 adds, stage 2 optionally
// negates a negative subtraction result back to magnitude form.
module add_subt_pipe
  import add_subt_pkg::*;
#(
  parameter int SWR      = SWR_DEFAULT,
  parameter bit NEG_CORR = 1'b1
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           in_valid_i,
  output logic           in_ready_o,
  input  logic           Add_Sub_op_i,
  input  logic [SWR-1:0] Data_A_i,
  input  logic [SWR-1:0] Data_B_i,
  output logic           out_valid_o,
  input  logic           out_ready_i,
  output logic [SWR-1:0] Data_Result_o,
  output logic [SWR-1:0] P_o,
  output logic [SWR-1:1] Cn_o,
  output logic           FSM_C_o,
  output logic           Sign_flip_o,
  output logic           Zero_o
);

  // Handshake: a beat moves across an interface on a rising edge where valid and
  // ready are both high; valid never depends on ready, and a stalled stage holds
  // its data stable until that handshake completes.

  logic [SWR-1:0] b_inv;
  logic [SWR-1:0] add_s;
  logic [SWR-1:0] add_p;
  logic [SWR-1:1] add_cn;
  logic           add_co;

  logic           v1;
  logic [SWR-1:0] s1_sum;
  logic [SWR-1:0] s1_p;
  logic [SWR-1:1] s1_cn;
  logic           s1_ovf;
  logic           s1_neg;

  logic           v2;
  logic [SWR-1:0] s2_res;
  logic [SWR-1:0] s2_p;
  logic [SWR-1:1] s2_cn;
  logic           s2_ovf;
  logic           s2_neg;
  logic           s2_zero;

  logic           adv1;
  logic           adv2;

  logic [NEG_MAX_W-1:SWR] neg_hi_unused;
  logic [SWR-1:0]         neg_lo;
  logic [SWR-1:0]         corr;

  assign b_inv = Data_B_i ^ {SWR{Add_Sub_op_i == OP_SUB}};

  pg_adder #(.SWR(SWR)) u_pg_adder (
    .a   (Data_A_i),
    .b   (b_inv),
    .cin (Add_Sub_op_i),
    .s   (add_s),
    .p   (add_p),
    .cn  (add_cn),
    .co  (add_co)
  );

  assign adv2       = v1 & (~v2 | out_ready_i);
  assign adv1       = in_valid_i & (~v1 | adv2);
  assign in_ready_o = ~v1 | ~v2 | out_ready_i;

  // Only the low SWR bits of the widened negate are meaningful (mod 2^SWR).
  assign {neg_hi_unused, neg_lo} = twos_negate(NEG_MAX_W'(s1_sum));
  assign corr = (s1_neg && NEG_CORR) ? neg_lo : s1_sum;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      v1      <= 1'b0;
      s1_sum  <= '0;
      s1_p    <= '0;
      s1_cn   <= '0;
      s1_ovf  <= 1'b0;
      s1_neg  <= 1'b0;
      v2      <= 1'b0;
      s2_res  <= '0;
      s2_p    <= '0;
      s2_cn   <= '0;
      s2_ovf  <= 1'b0;
      s2_neg  <= 1'b0;
      s2_zero <= 1'b0;
    end else begin
      v1 <= adv1 | (v1 & ~adv2);
      v2 <= adv2 | (v2 & ~out_ready_i);
      if (adv1) begin
        s1_sum <= add_s;
        s1_p   <= add_p;
        s1_cn  <= add_cn;
        s1_ovf <= add_co & ~Add_Sub_op_i;
        s1_neg <= Add_Sub_op_i & ~add_co;
      end
      if (adv2) begin
        s2_res  <= corr;
        s2_p    <= s1_p;
        s2_cn   <= s1_cn;
        s2_ovf  <= s1_ovf;
        s2_neg  <= s1_neg;
        s2_zero <= (corr == '0) && !s1_ovf;
      end
    end
  end

  assign out_valid_o   = v2;
  assign Data_Result_o = s2_res;
  assign P_o           = s2_p;
  assign Cn_o          = s2_cn;
  assign FSM_C_o       = s2_ovf;
  assign Sign_flip_o   = s2_neg;
  assign Zero_o        = s2_zero;

endmodule
